// File: rtl/otp_pad_scheduler.sv
// otp_pad_scheduler
//   Shares the one-time-pad register file and LFSR pad generator between an
//   encrypt and a decrypt requester. Round-robin arbitration, lowest-free slot
//   allocation on encrypt, single-use enforcement via a valid bitmap.
//
//   Optional feature macro: OTP_SCHED_ZEROIZE_EN
//     When defined, a successful decrypt spends one extra cycle (ZERO) writing
//     zero over the consumed pad slot before the response.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   enc_req/enc_data      encrypt request (held until enc_gnt) and plaintext
//   enc_gnt               one-cycle encrypt grant
//   dec_req/dec_slot/
//   dec_data              decrypt request, slot and ciphertext
//   dec_gnt               one-cycle decrypt grant
//   prn, prn_adv          LFSR output and advance strobe
//   pad_we/pad_wa/pad_wd  pad register-file write port
//   pad_ra/pad_rd         pad register-file read port (combinational read)
//   out_valid             one-cycle result strobe
//   out_data/out_slot/
//   out_err/out_dec       registered result fields (held between results)
//   used/full/empty       occupancy of the slot bitmap
module otp_pad_scheduler #(
  parameter int SLOTS = 8,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enc_req,
  input  logic [W-1:0]  enc_data,
  output logic          enc_gnt,
  input  logic          dec_req,
  input  logic [AW-1:0] dec_slot,
  input  logic [W-1:0]  dec_data,
  output logic          dec_gnt,
  input  logic [W-1:0]  prn,
  output logic          prn_adv,
  output logic          pad_we,
  output logic [AW-1:0] pad_wa,
  output logic [W-1:0]  pad_wd,
  output logic [AW-1:0] pad_ra,
  input  logic [W-1:0]  pad_rd,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_slot,
  output logic          out_err,
  output logic          out_dec,
  output logic [AW:0]   used,
  output logic          full,
  output logic          empty
);

  typedef enum logic [2:0] {
    IDLE,
    ENC,
    DEC,
`ifdef OTP_SCHED_ZEROIZE_EN
    ZERO,
`endif
    RESP
  } state_t;

  state_t          state, state_nx;
  logic [SLOTS-1:0] valid, valid_nx;
  logic            last_winner, last_winner_nx;   // 0 = enc, 1 = dec
  logic [W-1:0]    res_data, res_data_nx;
  logic [AW-1:0]   res_slot, res_slot_nx;
  logic            res_err, res_err_nx;
  logic            res_dec, res_dec_nx;

  logic [AW-1:0]   free_slot;
  logic            any_free;
  logic [AW:0]     cnt;

  // Descending scan so the lowest free index is the last assignment to win.
  always_comb begin
    free_slot = '0;
    any_free  = 1'b0;
    for (int unsigned i = SLOTS; i > 0; i--) begin
      if (!valid[i-1]) begin
        free_slot = AW'(i - 1);
        any_free  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      cnt = cnt + (AW+1)'(valid[i]);
    end
  end

  assign used  = cnt;
  assign full  = (cnt == (AW+1)'(SLOTS));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      last_winner <= 1'b1;
      res_data    <= '0;
      res_slot    <= '0;
      res_err     <= 1'b0;
      res_dec     <= 1'b0;
    end else begin
      state       <= state_nx;
      valid       <= valid_nx;
      last_winner <= last_winner_nx;
      res_data    <= res_data_nx;
      res_slot    <= res_slot_nx;
      res_err     <= res_err_nx;
      res_dec     <= res_dec_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    valid_nx       = valid;
    last_winner_nx = last_winner;
    res_data_nx    = res_data;
    res_slot_nx    = res_slot;
    res_err_nx     = res_err;
    res_dec_nx     = res_dec;
    enc_gnt        = 1'b0;
    dec_gnt        = 1'b0;
    prn_adv        = 1'b0;
    pad_we         = 1'b0;
    pad_wa         = '0;
    pad_wd         = '0;
    pad_ra         = '0;
    out_valid      = 1'b0;

    case (state)
      IDLE: begin
        // enc goes if alone, or on a tie when dec won last time
        if (enc_req && (!dec_req || last_winner)) begin
          state_nx = ENC;
        end else if (dec_req) begin
          state_nx = DEC;
        end
      end

      ENC: begin
        enc_gnt        = 1'b1;
        last_winner_nx = 1'b0;
        res_dec_nx     = 1'b0;
        state_nx       = RESP;
        if (any_free) begin
          pad_we              = 1'b1;
          pad_wa              = free_slot;
          pad_wd              = prn;
          prn_adv             = 1'b1;
          valid_nx[free_slot] = 1'b1;
          res_data_nx         = prn ^ enc_data;
          res_slot_nx         = free_slot;
          res_err_nx          = 1'b0;
        end else begin
          res_data_nx = '0;
          res_slot_nx = '0;
          res_err_nx  = 1'b1;
        end
      end

      DEC: begin
        dec_gnt        = 1'b1;
        last_winner_nx = 1'b1;
        pad_ra         = dec_slot;
        res_dec_nx     = 1'b1;
        res_slot_nx    = dec_slot;
        state_nx       = RESP;
        if (valid[dec_slot]) begin
          res_data_nx        = pad_rd ^ dec_data;
          res_err_nx         = 1'b0;
          valid_nx[dec_slot] = 1'b0;
`ifdef OTP_SCHED_ZEROIZE_EN
          state_nx           = ZERO;
`endif
        end else begin
          res_data_nx = '0;
          res_err_nx  = 1'b1;
        end
      end

`ifdef OTP_SCHED_ZEROIZE_EN
      ZERO: begin
        // res_slot already holds the consumed slot from the DEC cycle
        pad_we   = 1'b1;
        pad_wa   = res_slot;
        pad_wd   = '0;
        state_nx = RESP;
      end
`endif

      RESP: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign out_data = res_data;
  assign out_slot = res_slot;
  assign out_err  = res_err;
  assign out_dec  = res_dec;

endmodule

// File: tb/tb_otp_pad_scheduler.sv
module tb_otp_pad_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enc_req, dec_req;
  logic [7:0] enc_data, dec_data;
  logic [2:0] dec_slot;
  logic       enc_gnt, dec_gnt;
  logic [7:0] prn;
  logic       prn_adv;
  logic       pad_we;
  logic [2:0] pad_wa, pad_ra;
  logic [7:0] pad_wd, pad_rd;
  logic       out_valid, out_err, out_dec;
  logic [7:0] out_data;
  logic [2:0] out_slot;
  logic [3:0] used;
  logic       full, empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  otp_pad_scheduler #(.SLOTS(8), .AW(3), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_req(enc_req), .enc_data(enc_data), .enc_gnt(enc_gnt),
    .dec_req(dec_req), .dec_slot(dec_slot), .dec_data(dec_data), .dec_gnt(dec_gnt),
    .prn(prn), .prn_adv(prn_adv),
    .pad_we(pad_we), .pad_wa(pad_wa), .pad_wd(pad_wd),
    .pad_ra(pad_ra), .pad_rd(pad_rd),
    .out_valid(out_valid), .out_data(out_data), .out_slot(out_slot),
    .out_err(out_err), .out_dec(out_dec),
    .used(used), .full(full), .empty(empty)
  );

  // Pad storage and PRNG environment
  logic [7:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  always @(posedge clk) if (pad_we) mem[pad_wa] <= pad_wd;
  assign pad_rd = mem[pad_ra];

  always @(posedge clk) begin
    if (!rst_n)       prn <= 8'h3C;
    else if (prn_adv) prn <= {prn[6:0], prn[7] ^ prn[5] ^ prn[4] ^ prn[3]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_free(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (!v[i]) return i;
    return -1;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic       rst_q;
  always @(posedge clk) rst_q <= rst_n;

  logic [7:0] mvalid;
  logic [7:0] mpad [8];
  int         mphase;       // 0 idle, 1 grant, 2 wipe, 3 response
  logic       mwho;         // 0 enc, 1 dec
  logic       mlast;
  logic [7:0] h_data;
  logic [2:0] h_slot, mz;
  logic       h_err, h_dec;
  bit         mknown = 0;

  always @(negedge clk) begin
    int fs;
    logic e_we, e_adv;
    logic [2:0] e_wa, e_ra;
    logic [7:0] e_wd;
    if (rst_q === 1'b0) begin
      mvalid = '0; mphase = 0; mlast = 1'b1; mwho = 1'b0;
      h_data = '0; h_slot = '0; h_err = 1'b0; h_dec = 1'b0; mz = '0;
      mknown = 1;
    end
    if (mknown) begin
      fs = lowest_free(mvalid);
      e_we = 0; e_adv = 0; e_wa = '0; e_wd = '0; e_ra = '0;
      if (mphase == 1 && !mwho && fs >= 0) begin
        e_we = 1; e_wa = 3'(fs); e_wd = prn; e_adv = 1;
      end
      if (mphase == 1 && mwho) e_ra = dec_slot;
      if (mphase == 2) begin e_we = 1; e_wa = mz; e_wd = '0; end
      chk("enc_gnt",   enc_gnt,   (mphase == 1 && !mwho));
      chk("dec_gnt",   dec_gnt,   (mphase == 1 && mwho));
      chk("out_valid", out_valid, (mphase == 3));
      chk("pad_we",    pad_we,    e_we);
      chk("pad_wa",    pad_wa,    e_wa);
      chk("pad_wd",    pad_wd,    e_wd);
      chk("prn_adv",   prn_adv,   e_adv);
      chk("pad_ra",    pad_ra,    e_ra);
      chk("out_data",  out_data,  h_data);
      chk("out_slot",  out_slot,  h_slot);
      chk("out_err",   out_err,   h_err);
      chk("out_dec",   out_dec,   h_dec);
      chk("used",      used,      $countones(mvalid));
      chk("full",      full,      (mvalid == 8'hFF));
      chk("empty",     empty,     (mvalid == 8'h00));

      case (mphase)
        0: if (enc_req || dec_req) begin
             mwho   = (enc_req && dec_req) ? !mlast : dec_req;
             mphase = 1;
           end
        1: begin
             mlast  = mwho;
             mphase = 3;
             if (!mwho) begin
               h_dec = 1'b0;
               if (fs < 0) begin
                 h_data = '0; h_slot = '0; h_err = 1'b1;
               end else begin
                 mvalid[fs] = 1'b1;
                 mpad[fs]   = prn;
                 h_data = prn ^ enc_data; h_slot = 3'(fs); h_err = 1'b0;
               end
             end else begin
               h_dec  = 1'b1;
               h_slot = dec_slot;
               if (mvalid[dec_slot]) begin
                 h_data = mpad[dec_slot] ^ dec_data; h_err = 1'b0;
                 mvalid[dec_slot] = 1'b0;
`ifdef OTP_SCHED_ZEROIZE_EN
                 mz = dec_slot; mphase = 2;
`endif
               end else begin
                 h_data = '0; h_err = 1'b1;
               end
             end
           end
        2: mphase = 3;
        default: mphase = 0;
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  logic       g_we, g_adv;
  logic [2:0] g_wa;
  logic [7:0] g_wd;
  logic [7:0] r_data;
  logic [2:0] r_slot;
  logic       r_err, r_dec;
  logic [3:0] r_used;
  int         r_lat;

  task automatic wait_resp();
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    if (!out_valid) chk("resp_timeout", 0, 1);
    r_lat = n; r_data = out_data; r_slot = out_slot;
    r_err = out_err; r_dec = out_dec; r_used = used;
  endtask

  task automatic do_enc(input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1 enc_req = 1'b1; enc_data = d;
    do begin @(negedge clk); n++; end while (!enc_gnt && n < 20);
    if (!enc_gnt) chk("enc_gnt_timeout", 0, 1);
    g_we = pad_we; g_wa = pad_wa; g_wd = pad_wd; g_adv = prn_adv;
    @(posedge clk); #1 enc_req = 1'b0;
    wait_resp();
  endtask

  task automatic do_dec(input logic [2:0] s, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1 dec_req = 1'b1; dec_slot = s; dec_data = d;
    do begin @(negedge clk); n++; end while (!dec_gnt && n < 20);
    if (!dec_gnt) chk("dec_gnt_timeout", 0, 1);
    @(posedge clk); #1 dec_req = 1'b0;
    wait_resp();
  endtask

  initial begin
    logic [7:0] aborted_wd;
    int n;
    rst_n = 1'b0; enc_req = 0; dec_req = 0;
    enc_data = '0; dec_data = '0; dec_slot = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_used", used, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);

    // First encrypt: 0xA5 ^ 0x3C = 0x99 into slot 0
    do_enc(8'hA5);
    chk("enc1_wa", g_wa, 0);
    chk("enc1_wd", g_wd, 8'h3C);
    chk("enc1_data", r_data, 8'h99);
    chk("enc1_slot", r_slot, 0);
    chk("enc1_used", r_used, 1);
    chk("enc1_lat", r_lat, 1);

    // Decrypt slot 0, then reuse it
    do_dec(3'd0, 8'h99);
    chk("dec1_data", r_data, 8'hA5);
    chk("dec1_dec", r_dec, 1);
    chk("dec1_used", r_used, 0);
`ifdef OTP_SCHED_ZEROIZE_EN
    chk("dec1_lat", r_lat, 2);
`else
    chk("dec1_lat", r_lat, 1);
`endif
    do_dec(3'd0, 8'h99);
    chk("reuse_err", r_err, 1);
    chk("reuse_data", r_data, 0);

    // Nine encrypts: fill 0..7, ninth overflows
    for (int i = 0; i < 9; i++) begin
      do_enc(8'h10 + 8'(i));
      if (i < 8) chk("fill_slot", r_slot, i);
    end
    chk("ovf_err", r_err, 1);
    chk("ovf_data", r_data, 0);
    chk("ovf_we", g_we, 0);
    chk("ovf_adv", g_adv, 0);
    chk("ovf_full", full, 1);

    // Free slot 3, re-encrypt lands there
    do_dec(3'd3, 8'h00);
    chk("free3_err", r_err, 0);
    chk("free3_used", r_used, 7);
`ifdef OTP_SCHED_ZEROIZE_EN
    chk("free3_lat", r_lat, 2);
    chk("free3_wiped", mem[3], 0);
`endif
    do_enc(8'h77);
    chk("realloc_wa", g_wa, 3);

    // Both held from reset: enc, dec, enc, dec
    @(posedge clk); #1 rst_n = 1'b0;
    enc_req = 1'b1; dec_req = 1'b1; dec_slot = 3'd0; dec_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!enc_gnt && !dec_gnt && n < 20);
      chk("rr_gnt_seen", enc_gnt | dec_gnt, 1);
      chk("rr_order", dec_gnt, k % 2);
    end
    @(posedge clk); #1 enc_req = 1'b0; dec_req = 1'b0;
    repeat (4) @(posedge clk);

    // Reset during ENC aborts the transaction
    @(posedge clk); #1 enc_req = 1'b1; enc_data = 8'h42;
    n = 0;
    do begin @(negedge clk); n++; end while (!enc_gnt && n < 20);
    chk("abort_gnt_seen", enc_gnt, 1);
    aborted_wd = pad_wd;
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; enc_req = 1'b0;
    @(negedge clk);
    chk("abort_empty", empty, 1);
    chk("abort_used", used, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_out_err", out_err, 0);
    chk("abort_write_kept", mem[0], aborted_wd);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_valid", out_valid, 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
